apb_timer_cfg_arb: RTL

Two-requester APB master arbiter/sequencer that owns the APB bus into the timer slave and shares it between a CPU command port (req0) and a hardware reload/config sequencer (req1). It accepts one request at a time and arbitrates round-robin. It runs the full APB SETUP/ACCESS protocol, waits on pready with a bounded timeout, and returns read data and error status to the winning requester. It sits between the system-side requesters and the timer's APB slave port.

---
 rtl/apb_timer_pkg.sv | 17 +
 rtl/rr_arb2.sv | 26 ++
 rtl/apb_timer_cfg_arb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
// Shared types and timer register map for the APB timer config arbiter.
package apb_timer_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    localparam logic [ADDR_W_DEF-1:0] CTRL      = 10'h000;
    localparam logic [ADDR_W_DEF-1:0] VALUE     = 10'h001;
    localparam logic [ADDR_W_DEF-1:0] RELOAD    = 10'h002;
    localparam logic [ADDR_W_DEF-1:0] INTSTATUS = 10'h003;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the last winner only moves on an accepted grant.
module rr_arb2 (
    input  logic pclk,
    input  logic preset,
    input  logic v0,
    input  logic v1,
    input  logic en,
    output logic g0,
    output logic g1
);

    logic last;

    // last=1 after reset so requester 0 wins the first contest
    assign g0 = v0 & (~v1 | last);
    assign g1 = v1 & (~v0 | ~last);

    always_ff @(posedge pclk) begin
        if (preset) begin
            last <= 1'b1;
        end else if (en) begin
            last <= g1;
        end
    end

endmodule

// File: rtl/apb_timer_cfg_arb.sv
// APB master shared between a CPU port and a reload sequencer, with
// round-robin arbitration and a bounded pready wait.
module apb_timer_cfg_arb
    import apb_timer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

    state_e        state;
    state_e        state_nxt;
    logic          g0;
    logic          g1;
    logic          acc0;
    logic          acc1;
    logic          acc;
    logic          owner;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          hit;
    logic          done;
    logic          abort;

    rr_arb2 u_arb (
        .pclk   (pclk),
        .preset (preset),
        .v0     (req0_valid),
        .v1     (req1_valid),
        .en     (acc),
        .g0     (g0),
        .g1     (g1)
    );

    assign req0_ready = (state == IDLE) & g0;
    assign req1_ready = (state == IDLE) & g1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign acc        = acc0 | acc1;

    assign psel    = (state != IDLE);
    assign penable = (state == ACCESS);

    assign cnt_inc = cnt + 1'b1;
    assign hit     = (TIMEOUT_CYC != 0) && (cnt_inc == TMAX);

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // a ready slave beats the timeout in the same cycle
                if (pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            owner      <= 1'b0;
            cnt        <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rsp0_valid <= (done | abort) & ~owner;
            rsp1_valid <= (done | abort) & owner;
            if (acc) begin
                owner  <= acc1;
                pwrite <= acc1 ? req1_write : req0_write;
                paddr  <= acc1 ? req1_addr  : req0_addr;
                pwdata <= acc1 ? req1_wdata : req0_wdata;
                cnt    <= '0;
            end else if ((state == ACCESS) && !pready) begin
                cnt <= cnt_inc;
            end
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (abort) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule
